// File: rtl/fft_pkg.sv
// Shared helpers for the FFT input buffer: sizing, bit reversal and
// complex-word {im, re} field access.
package fft_pkg;

  localparam int unsigned CPLX_PARTS = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int unsigned cplx_width(input int unsigned data_width);
    return CPLX_PARTS * data_width;
  endfunction

  // Mirrors the low 'bits' bits of value; higher bits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
    logic [31:0] result;
    result = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) begin
        result[bits-1-i] = value[i];
      end
    end
    return result;
  endfunction

  function automatic logic [31:0] cplx_re(input logic [63:0] word, input int unsigned data_width);
    logic [63:0] mask;
    mask = (64'd1 << data_width) - 64'd1;
    return 32'(word & mask);
  endfunction

  function automatic logic [31:0] cplx_im(input logic [63:0] word, input int unsigned data_width);
    logic [63:0] mask;
    mask = (64'd1 << data_width) - 64'd1;
    return 32'((word >> data_width) & mask);
  endfunction

endpackage

// File: rtl/fft_in_bank.sv
// One N-entry complex register bank: bit-reversed write port, butterfly pair read port.
module fft_in_bank
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en_i,
  input  logic [clog2(N_POINTS)-1:0]           wr_idx_i,
  input  logic [cplx_width(DATA_WIDTH)-1:0]    wr_data_i,
  input  logic [clog2(N_POINTS)-2:0]           rd_pair_i,
  output logic [cplx_width(DATA_WIDTH)-1:0]    rd_a_o,
  output logic [cplx_width(DATA_WIDTH)-1:0]    rd_b_o
);

  localparam int unsigned AW = clog2(N_POINTS);
  localparam int unsigned CW = cplx_width(DATA_WIDTH);

  logic [CW-1:0] mem_q [N_POINTS];
  logic [31:0]   rev_full_s;
  logic [AW-1:0] wr_addr_s;
  logic          unused_rev_s;

  assign rev_full_s   = bitrev(32'(wr_idx_i), AW);
  assign wr_addr_s    = rev_full_s[AW-1:0];
  assign unused_rev_s = ^rev_full_s[31:AW];

  // Storage: cleared on reset, one entry written per accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_POINTS); i++) begin
        mem_q[i] <= {CW{1'b0}};
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_s] <= wr_data_i;
    end
  end

  assign rd_a_o = mem_q[{rd_pair_i, 1'b0}];
  assign rd_b_o = mem_q[{rd_pair_i, 1'b1}];

endmodule

// File: rtl/fft_in_buffer.sv
// Ping-pong input buffer for a radix-2 DIT FFT: natural-order writes,
// bit-reversed storage, first-stage butterfly pairs out.
module fft_in_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [cplx_width(DATA_WIDTH)-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [cplx_width(DATA_WIDTH)-1:0] out_a,
  output logic [cplx_width(DATA_WIDTH)-1:0] out_b,
  output logic [clog2(N_POINTS)-2:0]        out_pair,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last
);

  localparam int unsigned AW = clog2(N_POINTS);
  localparam int unsigned PW = AW - 1;
  localparam int unsigned CW = cplx_width(DATA_WIDTH);
  localparam logic [AW-1:0] WR_LAST = AW'(N_POINTS - 1);
  localparam logic [PW-1:0] RD_LAST = PW'(N_POINTS / 2 - 1);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [PW-1:0] rd_cnt_q, rd_cnt_d;

  logic          wr_fire_s, rd_fire_s, rd_last_s;
  logic [CW-1:0] bank_a_s [2];
  logic [CW-1:0] bank_b_s [2];

  // in_ready only looks at registered state, so out_ready never reaches it.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire_s = in_valid & in_ready;
  assign rd_fire_s = out_valid & out_ready;
  assign rd_last_s = (rd_cnt_q == RD_LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_in_bank #(
      .N_POINTS  (N_POINTS),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_fire_s && (wr_bank_q == 1'(b))),
      .wr_idx_i (wr_cnt_q),
      .wr_data_i(in_data),
      .rd_pair_i(rd_cnt_q),
      .rd_a_o   (bank_a_s[b]),
      .rd_b_o   (bank_b_s[b])
    );
  end

  // Next state for writer and reader; both may complete in the same cycle
  // on different banks, so each touches only its own full bit.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;

    if (wr_fire_s) begin
      if (wr_cnt_q == WR_LAST) begin
        wr_cnt_d          = {AW{1'b0}};
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    if (rd_fire_s) begin
      if (rd_last_s) begin
        rd_cnt_d          = {PW{1'b0}};
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_cnt_d = rd_cnt_q + PW'(1);
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Counter, bank pointer and full-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= {AW{1'b0}};
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= {PW{1'b0}};
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Read path is combinational; data is zeroed whenever no pair is offered.
  always_comb begin
    if (out_valid) begin
      out_a    = bank_a_s[rd_bank_q];
      out_b    = bank_b_s[rd_bank_q];
      out_pair = rd_cnt_q;
      out_last = rd_last_s;
    end else begin
      out_a    = {CW{1'b0}};
      out_b    = {CW{1'b0}};
      out_pair = {PW{1'b0}};
      out_last = 1'b0;
    end
  end

endmodule

// File: doc/fft_in_buffer.md
# fft_in_buffer

Ping-pong input buffer for an N-point radix-2 DIT FFT. It accepts complex samples serially in natural order over a valid/ready handshake and stores each one at its bit-reversed address. It then presents first-stage butterfly operand pairs, one pair per handshake, to the butterfly datapath. Two banks allow the next frame to be written while the current frame drains.

## Interface
- `N_POINTS`, default 8: FFT size; power of two, ≥ 4.
- `DATA_WIDTH`, default 8: width of each real and imaginary part; a complex word is `{im, re}`, 2*DATA_WIDTH bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_data` in 2*DATA_WIDTH: complex sample `{im, re}`.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: buffer can accept a sample.
- `out_a` out 2*DATA_WIDTH: butterfly top operand, memory entry 2k.
- `out_b` out 2*DATA_WIDTH: butterfly bottom operand, memory entry 2k+1.
- `out_pair` out log2(N_POINTS)-1: pair index k.
- `out_valid` out 1: pair on outputs is valid.
- `out_ready` in 1: consumer takes the pair.
- `out_last` out 1: the current pair is the final pair of its frame (k = N/2-1).

## Operation
- State:
  - two banks of N complex registers;
  - `full[1:0]`;
  - `wr_bank`, `wr_cnt` (log2 N bits);
  - `rd_bank`, `rd_cnt` (log2 N − 1 bits).
- Write:
  - Accept when `in_valid && in_ready`, with `in_ready = !full[wr_bank]`.
  - The sample goes to bank `wr_bank`, entry `bitrev(wr_cnt)`; `wr_cnt` increments.
  - On the N-th accept: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_cnt` to 0.
- Read:
  - `out_valid = full[rd_bank]`.
  - `out_a` = entry `2*rd_cnt` of `rd_bank`; `out_b` = entry `2*rd_cnt+1`; `out_pair = rd_cnt`; `out_last = out_valid && rd_cnt == N/2-1`.
  - Pair consumed when `out_valid && out_ready`; `rd_cnt` increments.
  - On the last pair: clear `full[rd_bank]`, toggle `rd_bank`, wrap `rd_cnt` to 0.
- `out_a`, `out_b` and `out_pair` are forced to 0 while `out_valid` is low.
- Bank state per bank: EMPTY/FILLING (`full = 0`, owned by the writer) → FULL/DRAINING (`full = 1`, owned by the reader) → back to EMPTY after its last pair.
- Boundaries:
  - Both banks full: `in_ready` is 0 and `in_data` is ignored. Nothing is overwritten.
  - Simultaneous completion: the writer finishing one bank and the reader releasing the other in the same cycle apply both updates. No frame is lost or duplicated.
  - A bank is never written while `full`, so draining data stays stable under backpressure.
  - Outputs hold their value while `out_valid && !out_ready`.
  - Reset mid-operation discards all frames, including partial ones. The writer restarts at bank 0, sample 0.
- Reset values: all counters, bank pointers and `full` are 0. Bank contents are cleared to 0. `in_ready` = 1; `out_valid` = `out_last` = 0; `out_a` = `out_b` = `out_pair` = 0.

## Timing
- Write accept: the sample is registered at the accepting edge.
- Latency: if the N-th sample is accepted at edge t, `out_valid` is high in the cycle after t with pair 0. This is one cycle from last write to first pair.
- Read path: combinational from the bank registers and `rd_cnt` to the outputs. There is no output register.
- Throughput:
  - writer: 1 sample/cycle; reader: 1 pair/cycle.
  - A frame drains in N/2 cycles, so continuous input streams with no `in_ready` deassertion when `out_ready` is held at 1.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.

## Structure
- Shared package `fft_pkg`:
  - `clog2` function;
  - `bitrev(value, bits)` function;
  - complex-word width constant/macro (2*DATA_WIDTH);
  - `{im, re}` field slicing helpers.
- Sub-module `fft_in_bank`: one N-entry register bank with a bit-reversed write port (enable, index, data) and a pair read port (k → entries 2k, 2k+1). It is instantiated twice; the top holds the counters, `full` flags and handshake logic.

## Test plan
- Reset and idle: hold `rst` low, then release. Required: `in_ready` = 1, `out_valid` = 0, all outputs 0, with no `in_valid`.
- Bit reversal, N=8: write samples with `re = i`, `im = 0x80+i` for i = 0..7, with `out_ready` = 1. Required: pairs (`re`) come out as (0,4), (2,6), (1,5), (3,7) with `out_pair` 0..3; `out_last` is set only on k=3; first `out_valid` is one cycle after the 8th accept.
- Backpressure: N=8, `out_ready` = 0, offer 17 samples back-to-back. Required: `in_ready` falls after the 16th accept; the 17th is held. Releasing `out_ready` drains frame 0, then frame 1, in order, and the 17th is then accepted.
- Output stall: deassert `out_ready` mid-frame at k=1. Required: `out_a`, `out_b` and `out_pair` stay stable until `out_ready` returns, then continue at k=2.
- Simultaneous completion: time the writer's 8th sample of frame 1 to coincide with the reader's last pair of frame 0. Required: frame 1 becomes valid next cycle, `full` = 2'b10 → reader on bank 1, and no sample is lost.
- Reset mid-frame: assert `rst` after 5 samples of a frame. Required: outputs return to reset values; the next 8 samples form a complete frame starting at bank 0.
